mux_nx1_stream: RTL

//   Parametrised N-input, W-bit stream multiplexer; successor to the 2:1 combinational mux.

---
 rtl/mux_nx1_stream_if.sv | 28 ++
 rtl/mux_nx1_stream.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mux_nx1_stream_if.sv
// Stream bundle for mux_nx1_stream: N valid/ready input channels plus one
// registered output stream. The slave modport is the mux; the master modport
// is whoever drives the producers and the consumer.
interface mux_nx1_stream_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  localparam int unsigned SELW = $clog2(N);

  logic [N*W-1:0]  i_data;
  logic [N-1:0]    i_valid;
  logic [N-1:0]    i_ready;
  logic [SELW-1:0] s;
  logic [W-1:0]    y;
  logic            y_valid;
  logic            y_ready;
  logic [SELW-1:0] y_ch;

  modport master (
    output i_data, i_valid, s, y_ready,
    input  i_ready, y, y_valid, y_ch
  );

  modport slave (
    input  i_data, i_valid, s, y_ready,
    output i_ready, y, y_valid, y_ch
  );
endinterface

// File: rtl/mux_nx1_stream.sv
// N-input, W-bit valid/ready stream multiplexer with one registered output.
// MODE=0 selects the channel from s; MODE=1 uses round-robin arbitration.
// Optional feature macro MUX_XFER_CNT_EN adds a 16-bit wrapping xfer_cnt
// output counting beats taken by the consumer.
module mux_nx1_stream #(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_nx1_stream_if.slave  bus
`ifdef MUX_XFER_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);
  localparam int unsigned SELW = $clog2(N);

  logic [W-1:0]    y_q;
  logic            y_valid_q;
  logic [SELW-1:0] y_ch_q;

  logic            load;
  logic            grant_valid;
  logic [SELW-1:0] grant;
  logic [W-1:0]    sel_data;
  logic            sel_valid;
  logic            accept;
  logic [N-1:0]    ready;

  // Output register can take a new beat when empty or draining this cycle.
  assign load = !y_valid_q || bus.y_ready;

  if (MODE == 0) begin : g_ext_sel
    // External select; codes at or beyond N grant nothing.
    always_comb begin
      grant       = bus.s;
      grant_valid = (32'(bus.s) < N);
    end
  end else begin : g_rr
    logic [SELW-1:0] ptr;

    // Round-robin scan starting at ptr, wrapping at N.
    always_comb begin : rr_scan
      int unsigned idx;
      idx         = 0;
      grant       = '0;
      grant_valid = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        idx = 32'(ptr) + i;
        if (idx >= N) idx = idx - N;
        if (!grant_valid && bus.i_valid[idx]) begin
          grant       = SELW'(idx);
          grant_valid = 1'b1;
        end
      end
    end

    // Pointer moves to the channel after the one just accepted.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ptr <= '0;
      end else if (accept) begin
        ptr <= (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
      end
    end
  end

  // Decode the granted channel without indexing past N (keeps out-of-range s X-free).
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant == SELW'(k)) begin
        sel_data  = bus.i_data[k*W +: W];
        sel_valid = bus.i_valid[k];
      end
    end
  end

  // One-hot ready to the granted channel; held low while in reset.
  always_comb begin
    ready = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (rst_n && load && grant_valid && (grant == SELW'(k))) ready[k] = 1'b1;
    end
  end

  assign accept      = rst_n && load && grant_valid && sel_valid;
  assign bus.i_ready = ready;

  // Output register: load on accept, clear valid on a drain with nothing to load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_ch_q    <= '0;
    end else if (accept) begin
      y_q       <= sel_data;
      y_valid_q <= 1'b1;
      y_ch_q    <= grant;
    end else if (bus.y_ready) begin
      y_valid_q <= 1'b0;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_ch    = y_ch_q;

`ifdef MUX_XFER_CNT_EN
  // Count beats taken by the consumer; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= 16'd0;
    end else if (y_valid_q && bus.y_ready) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule
